// File: rtl/alu_exec_stage_pkg.sv
// Shared encodings for the execute stage and the ALU it drives: opcodes, instruction layout, FSM states.
// Kept in one package so the stage's decode and the ALU's opcode table cannot drift apart.
package alu_exec_stage_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_NREGS  = 4;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;

  // Field layout; in register mode rs2 lives in imm7[1:0].
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic       src_sel;
    logic [6:0] imm7;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_exec_stage_regfile_4x8.sv
// Register file: two combinational operand reads, one combinational debug read, one synchronous write.
// Zero latency on reads, write visible the cycle after the write edge; synchronous clear on rst.
module regfile_4x8 #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around an external 8-bit ALU: IDLE accepts, EXEC drives ALU, WB pulses done.
// One instruction per 3 clocks; instr_ready is high only in IDLE, no skid buffering.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREGS  = ALU_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        alu_operation,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              wb_done,
  output logic              wb_illegal,
  output logic              flag_z,
  output logic              flag_v,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int AW = $clog2(NREGS);

  instr_t            ins;
  state_e            state;
  logic              legal_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] operand2_next;
  logic              rf_wr_en;

  assign ins         = instr;
  assign instr_ready = (state == ST_IDLE);
  assign rf_wr_en    = (state == ST_EXEC) && legal_q;

  // Immediate is zero-extended; register mode borrows the low imm bits as rs2.
  assign operand2_next = ins.src_sel ? {{(DATA_W-7){1'b0}}, ins.imm7} : rs2_data;

  regfile_4x8 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rf_wr_en),
    .wr_addr  (rd_q),
    .wr_data  (alu_result),
    .rd_addr1 (ins.rs1),
    .rd_data1 (rs1_data),
    .rd_addr2 (ins.imm7[1:0]),
    .rd_data2 (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      legal_q       <= 1'b0;
      rd_q          <= '0;
      alu_operation <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      flag_z        <= 1'b0;
      flag_v        <= 1'b0;
      wb_done       <= 1'b0;
      wb_illegal    <= 1'b0;
    end else begin
      wb_done    <= 1'b0;
      wb_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            alu_operation <= ins.op;
            alu_operand1  <= rs1_data;
            alu_operand2  <= operand2_next;
            rd_q          <= ins.rd;
            legal_q       <= op_is_legal(ins.op);
            state         <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Register file write for this edge is issued via rf_wr_en.
          if (legal_q) begin
            flag_z <= alu_zero;
            flag_v <= alu_overflow;
          end
          wb_done    <= legal_q;
          wb_illegal <= !legal_q;
          state      <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU, spec-level reference model, scoreboard queue and monitor.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  alu_operation;
  logic [7:0]  alu_operand1, alu_operand2;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_overflow;
  logic        wb_done, wb_illegal, flag_z, flag_v;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  always #10 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .wb_done(wb_done), .wb_illegal(wb_illegal), .flag_z(flag_z), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: carry on ADD, borrow on SUB, shifts by operand2[3:0].
  always_comb begin
    logic [8:0] t;
    t            = '0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_operation)
      4'h0: begin t = {1'b0, alu_operand1} + {1'b0, alu_operand2}; alu_result = t[7:0]; alu_overflow = t[8]; end
      4'h2: begin t = {1'b0, alu_operand1} - {1'b0, alu_operand2}; alu_result = t[7:0]; alu_overflow = t[8]; end
      4'h3: alu_result = alu_operand1 & alu_operand2;
      4'h4: alu_result = alu_operand1 | alu_operand2;
      4'h5: alu_result = alu_operand1 ^ alu_operand2;
      4'hD: alu_result = alu_operand1 << alu_operand2[3:0];
      4'hE: alu_result = alu_operand1 >> alu_operand2[3:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  typedef struct {
    bit illegal;
    int acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_rf[4];
  bit         ref_z, ref_v;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  int         chk_req = 0, chk_done = 0;
  int         last_acc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic void note_timeout(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endfunction

  function automatic logic [15:0] enc(int op, int rd, int rs1, int sel, int imm);
    return {op[3:0], rd[1:0], rs1[1:0], sel[0], imm[6:0]};
  endfunction

  // Reference model, applied at the accept edge with operands from the pre-write register file.
  function automatic void model_accept(logic [15:0] i, int acc);
    int op, rd, a, b, r;
    bit legal, v;
    exp_t e;
    op = int'(i[15:12]);
    rd = int'(i[11:10]);
    a  = int'(ref_rf[i[9:8]]);
    b  = i[7] ? int'(i[6:0]) : int'(ref_rf[i[1:0]]);
    legal = op inside {0, 2, 3, 4, 5, 13, 14};
    r = 0;
    v = 1'b0;
    case (op)
      0:  begin r = a + b; v = (r > 255); r = r % 256; end
      2:  begin r = a - b; v = (r < 0); r = (r + 256) % 256; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      13: r = (a * (1 << (b % 16))) % 256;
      14: r = a / (1 << (b % 16));
      default: r = 0;
    endcase
    if (legal) begin
      ref_rf[rd] = 8'(r);
      ref_z      = (r == 0);
      ref_v      = v;
    end
    e.illegal = !legal;
    e.acc     = acc;
    exp_q.push_back(e);
  endfunction

  task automatic compare_rf(string tag);
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 2'(k);
      #1;
      chk($sformatf("%s_rf%0d", tag, k), {24'h0, dbg_data}, {24'h0, ref_rf[k]});
    end
    chk({tag, "_flag_z"}, {31'h0, flag_z}, {31'h0, ref_z});
    chk({tag, "_flag_v"}, {31'h0, flag_v}, {31'h0, ref_v});
  endtask

  // Monitor: pops on every retirement pulse; also serves post-reset state checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_done || wb_illegal) begin
        if (exp_q.size() == 0) begin
          note_timeout("unexpected_retire_pulse");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_done", {31'h0, wb_done}, {31'h0, !e.illegal});
          chk("wb_illegal", {31'h0, wb_illegal}, {31'h0, e.illegal});
          chk("retire_latency", cyc - e.acc, 1);
          compare_rf("wb");
        end
      end
      if (chk_req != chk_done) begin
        chk("rst_instr_ready", {31'h0, instr_ready}, 1);
        chk("rst_wb_pulses", {30'h0, wb_done, wb_illegal}, 0);
        chk("rst_alu_regs", {12'h0, alu_operation, alu_operand1, alu_operand2}, 0);
        compare_rf("rst");
        chk_done = chk_req;
      end
    end
  end

  task automatic send(input logic [15:0] i, input bit check_gap);
    int w;
    w = 0;
    instr_valid = 1'b1;
    while (!instr_ready) begin
      instr = 16'($urandom);
      @(negedge clk);
      w++;
      if (w > 20) begin
        note_timeout("accept_wait");
        return;
      end
    end
    instr = i;
    @(posedge clk);
    @(negedge clk);
    model_accept(i, cyc);
    if (check_gap) chk("accept_gap", cyc - last_acc, 3);
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_retired();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) note_timeout("retire_wait");
  endtask

  task automatic do_reset();
    int w;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) ref_rf[k] = 8'h00;
    ref_z = 1'b0;
    ref_v = 1'b0;
    exp_q.delete();
    chk_req++;
    w = 0;
    while (chk_req != chk_done && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (chk_req != chk_done) note_timeout("reset_check_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    do_reset();

    send(16'h0485, 1'b0);                  // ADD r1,r0,#5
    send(enc(13, 2, 1, 1, 4), 1'b0);       // SHL r2,r1,#4 (held valid)
    send(enc(0, 3, 2, 0, 2), 1'b0);        // ADD r3,r2,r2
    send(enc(0, 3, 3, 0, 3), 1'b0);        // ADD r3,r3,r3 -> carry
    idle(2);
    send(16'h2501, 1'b0);                  // SUB r1,r1,r1 -> Z
    send(enc(1, 2, 3, 1, 9), 1'b0);        // illegal opcode, rd=r2
    send(enc(2, 0, 0, 1, 1), 1'b0);        // SUB r0,r0,#1 -> borrow
    idle(3);
    wait_retired();

    // Back-to-back with valid held high; garbage instr while not ready.
    send(enc(5, 1, 0, 1, 7'h2A), 1'b0);
    send(enc(4, 2, 1, 1, 7'h11), 1'b1);
    send(enc(3, 3, 2, 0, 1), 1'b1);
    send(enc(14, 0, 3, 1, 2), 1'b1);
    idle(3);
    wait_retired();

    // Reset while the accepted ADD is in EXEC.
    do_reset();
    send(16'h0485, 1'b0);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      send(16'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(4);
    wait_retired();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
